gsim_residual: RTL and testbench

GSIM_RESIDUAL -- requirements
Module: gsim_residual

---
 rtl/gsim_pkg.sv | 22 ++
 rtl/gsim_row_mac.sv | 31 +++
 rtl/gsim_residual.sv | 117 +++++++++++
 tb/tb_gsim_residual.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants, band coefficients and FSM state type for the GSIM solver family.
package gsim_pkg;

    localparam int N    = 16;
    localparam int B_W  = 16;
    localparam int X_W  = 32;
    localparam int R_W  = 40;
    localparam int FRAC = 16;

    // Symmetric band of M: diagonal, then offsets 1..3
    localparam int C0 = 20;
    localparam int C1 = -13;
    localparam int C2 = 6;
    localparam int C3 = -1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } gsim_state_t;

endpackage

// File: rtl/gsim_row_mac.sv
// One residual row r_j = sum(coef*x) - (b_j << FRAC), shift-add only, full 40-bit precision.
module gsim_row_mac
    import gsim_pkg::*;
(
    input  logic signed [X_W-1:0] x_m3,
    input  logic signed [X_W-1:0] x_m2,
    input  logic signed [X_W-1:0] x_m1,
    input  logic signed [X_W-1:0] x_0,
    input  logic signed [X_W-1:0] x_p1,
    input  logic signed [X_W-1:0] x_p2,
    input  logic signed [X_W-1:0] x_p3,
    input  logic signed [B_W-1:0] b_j,
    output logic signed [R_W-1:0] r_j
);

    logic signed [R_W-1:0] d, s1, s2, s3, b_ext;

    // Symmetric band: pair the taps first so each coefficient is applied once
    assign d     = {{(R_W-X_W){x_0[X_W-1]}}, x_0};
    assign s1    = {{(R_W-X_W){x_m1[X_W-1]}}, x_m1} + {{(R_W-X_W){x_p1[X_W-1]}}, x_p1};
    assign s2    = {{(R_W-X_W){x_m2[X_W-1]}}, x_m2} + {{(R_W-X_W){x_p2[X_W-1]}}, x_p2};
    assign s3    = {{(R_W-X_W){x_m3[X_W-1]}}, x_m3} + {{(R_W-X_W){x_p3[X_W-1]}}, x_p3};
    assign b_ext = {{(R_W-B_W-FRAC){b_j[B_W-1]}}, b_j, {FRAC{1'b0}}};

    assign r_j = (d <<< 4) + (d <<< 2)
               - ((s1 <<< 3) + (s1 <<< 2) + s1)
               + (s2 <<< 2) + (s2 <<< 1)
               - s3
               - b_ext;

endmodule

// File: rtl/gsim_residual.sv
// Frame residual checker: buffers b and x, evaluates M*x - b one row per cycle, flags pass/fail.
module gsim_residual
    import gsim_pkg::*;
#(
    parameter int             N   = 16,
    parameter logic [R_W-1:0] TOL = 40'd64
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    input  logic signed [B_W-1:0] b_in,
    input  logic                  x_valid,
    input  logic signed [X_W-1:0] x_in,
    output logic                  r_valid,
    output logic signed [R_W-1:0] r_out,
    output logic [3:0]            r_idx,
    output logic                  done,
    output logic                  pass
);

    localparam logic [4:0] FULL = 5'(N);

    logic signed [B_W-1:0] b_buf [16];
    logic signed [X_W-1:0] x_buf [16];
    logic [4:0]            b_cnt, x_cnt, b_cnt_nx, x_cnt_nx;
    logic [3:0]            row;
    gsim_state_t           state;
    logic                  acc_ok;
    logic                  b_take, x_take;
    logic signed [X_W-1:0] tap [7];
    logic signed [R_W-1:0] r_row;
    logic [R_W-1:0]        r_abs;
    logic                  row_ok;

    assign b_take   = (state == IDLE) && in_en   && (b_cnt < FULL);
    assign x_take   = (state == IDLE) && x_valid && (x_cnt < FULL);
    assign b_cnt_nx = b_cnt + {4'b0000, b_take};
    assign x_cnt_nx = x_cnt + {4'b0000, x_take};

    // Buffers are gated by the counters, so they need no reset
    always_ff @(posedge clk) begin
        if (b_take) b_buf[b_cnt[3:0]] <= b_in;
        if (x_take) x_buf[x_cnt[3:0]] <= x_in;
    end

    // Window x[row-3..row+3]; pos = row+k, tap index pos-3, zero outside 0..15
    always_comb begin
        logic [5:0] pos;
        pos = '0;
        for (int unsigned k = 0; k < 7; k++) begin
            pos    = {2'b00, row} + 6'(k);
            tap[k] = (pos >= 6'd3 && pos <= 6'd18) ? x_buf[4'(pos - 6'd3)] : '0;
        end
    end

    gsim_row_mac u_row_mac (
        .x_m3 (tap[0]),
        .x_m2 (tap[1]),
        .x_m1 (tap[2]),
        .x_0  (tap[3]),
        .x_p1 (tap[4]),
        .x_p2 (tap[5]),
        .x_p3 (tap[6]),
        .b_j  (b_buf[row]),
        .r_j  (r_row)
    );

    assign r_abs  = r_row[R_W-1] ? -r_row : r_row;
    assign row_ok = (r_abs <= TOL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            b_cnt   <= '0;
            x_cnt   <= '0;
            row     <= '0;
            acc_ok  <= 1'b1;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_idx   <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            case (state)
                IDLE: begin
                    b_cnt <= b_cnt_nx;
                    x_cnt <= x_cnt_nx;
                    if (b_cnt_nx == FULL && x_cnt_nx == FULL) begin
                        state <= CALC;
                        row   <= '0;
                    end
                end
                CALC: begin
                    r_valid <= 1'b1;
                    r_idx   <= row;
                    r_out   <= r_row;
                    acc_ok  <= acc_ok & row_ok;
                    row     <= row + 4'd1;
                    if (row == 4'(N - 1)) state <= DONE;
                end
                DONE: begin
                    done   <= 1'b1;
                    pass   <= acc_ok;
                    b_cnt  <= '0;
                    x_cnt  <= '0;
                    acc_ok <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_residual.sv
// Bench for gsim_residual: table frames, golden solve, random frames, mid-CALC reset.
module tb_gsim_residual;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_en;
    logic signed [15:0] b_in;
    logic               x_valid;
    logic signed [31:0] x_in;
    logic               r_valid;
    logic signed [39:0] r_out;
    logic [3:0]         r_idx;
    logic               done;
    logic               pass;

    always #5 clk = ~clk;

    gsim_residual #(.N(16), .TOL(40'd64)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_en   (in_en),
        .b_in    (b_in),
        .x_valid (x_valid),
        .x_in    (x_in),
        .r_valid (r_valid),
        .r_out   (r_out),
        .r_idx   (r_idx),
        .done    (done),
        .pass    (pass)
    );

    // mode: 0 simultaneous, 1 gapped random, 2 x before b, 3 b then 17th b then x
    typedef struct packed {
        logic [15:0][15:0] b;
        logic [15:0][31:0] x;
        logic [1:0]        mode;
        logic              exp_pass;
    } vec_t;

    int     checks = 0;
    int     failures = 0;
    int     pcyc = 0;
    longint rq_val[$];
    int     rq_idx[$];
    int     rq_cyc[$];
    int     done_cnt = 0;
    int     done_cyc = 0;
    logic   done_pass = 1'b0;
    int     stray = 0;
    int     last_drive = 0;
    vec_t   tbl [7];
    real    xr [16];

    always @(posedge clk) pcyc++;

    always @(negedge clk) begin
        if (r_valid) begin
            rq_val.push_back(longint'(r_out));
            rq_idx.push_back(int'(r_idx));
            rq_cyc.push_back(pcyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc  = pcyc;
            done_pass = pass;
        end
        if (pass && !done) stray++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint coef(input int d);
        int a;
        a = (d < 0) ? -d : d;
        case (a)
            0: return 20;
            1: return -13;
            2: return 6;
            3: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic longint model_r(input vec_t v, input int j);
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) s += coef(j - k) * longint'($signed(v.x[k]));
        return s - longint'($signed(v.b[j])) * 65536;
    endfunction

    function automatic bit model_pass(input vec_t v);
        longint r;
        for (int j = 0; j < 16; j++) begin
            r = model_r(v, j);
            if (r > 64 || r < -64) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_frame(input vec_t v);
        int bi = 0;
        int xi = 0;
        bit extra = 1'b0;
        bit be, xe;
        while (bi < 16 || xi < 16) begin
            @(negedge clk);
            be = 1'b0;
            xe = 1'b0;
            case (v.mode)
                2'd0: begin be = (bi < 16); xe = (xi < 16); end
                2'd1: begin
                    be = (bi < 16) && ($urandom_range(0, 2) != 0);
                    xe = (xi < 16) && ($urandom_range(0, 2) != 0);
                end
                2'd2: begin xe = (xi < 16); be = (xi >= 16) && (bi < 16); end
                default: begin be = (bi < 16) || !extra; xe = !be && (xi < 16); end
            endcase
            in_en   = be;
            x_valid = xe;
            b_in    = (be && bi < 16) ? $signed(v.b[bi]) : 16'sh7abc;
            x_in    = xe ? $signed(v.x[xi]) : $signed($urandom);
            if (be && bi >= 16) extra = 1'b1;
            if (be && bi < 16) bi++;
            if (xe) xi++;
            if (be || xe) last_drive = pcyc;
        end
    endtask

    // Garbage is driven while the frame computes; it must be dropped
    task automatic run_frame(input vec_t v, input string tag);
        int d0, n;
        rq_val.delete();
        rq_idx.delete();
        rq_cyc.delete();
        d0 = done_cnt;
        send_frame(v);
        n = 0;
        while (done_cnt == d0 && n < 80) begin
            @(negedge clk);
            #1;
            if (done_cnt == d0) begin
                in_en   = 1'b1;
                x_valid = 1'b1;
                b_in    = $signed(16'($urandom));
                x_in    = $signed($urandom);
            end
            n++;
        end
        in_en   = 1'b0;
        x_valid = 1'b0;
        chk({tag, "_done_count"}, longint'(done_cnt - d0), 1);
        chk({tag, "_r_count"}, longint'(rq_val.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rq_val.size()) begin
                chk($sformatf("%s_idx%0d", tag, i), longint'(rq_idx[i]), longint'(i));
                chk($sformatf("%s_r%0d", tag, i), rq_val[i], model_r(v, i));
            end
        end
        if (rq_cyc.size() > 0)
            chk({tag, "_first_r_latency"}, longint'(rq_cyc[0]), longint'(last_drive + 2));
        chk({tag, "_done_latency"}, longint'(done_cyc), longint'(last_drive + 18));
        chk({tag, "_pass"}, longint'(done_pass), longint'(model_pass(v)));
    endtask

    initial begin
        vec_t v;
        int   xi [16];
        int   n, d0;
        longint s;

        reset   = 1'b0;
        in_en   = 1'b0;
        x_valid = 1'b0;
        b_in    = '0;
        x_in    = '0;

        for (int i = 0; i < 7; i++) tbl[i] = '0;
        tbl[0].exp_pass = 1'b1;
        tbl[1].x[0]     = 32'h0001_0000;
        tbl[2].x[0]     = 32'h0001_0000;
        tbl[2].b[0]     = 16'sd20;
        tbl[2].b[1]     = -16'sd13;
        tbl[2].b[2]     = 16'sd6;
        tbl[2].b[3]     = -16'sd1;
        tbl[2].mode     = 2'd1;
        tbl[2].exp_pass = 1'b1;
        tbl[3].x[15]    = 32'h0001_0000;
        tbl[3].b[15]    = 16'sd20;
        tbl[3].b[14]    = -16'sd13;
        tbl[3].b[13]    = 16'sd6;
        tbl[3].b[12]    = -16'sd1;
        tbl[3].mode     = 2'd2;
        tbl[3].exp_pass = 1'b1;
        tbl[4]          = tbl[2];
        tbl[4].mode     = 2'd3;
        // Exact integer solution, then x7 nudged by 3 lsb (row error 60) or 4 lsb (80)
        for (int k = 0; k < 16; k++) xi[k] = int'($urandom_range(0, 10)) - 5;
        for (int j = 0; j < 16; j++) begin
            s = 0;
            for (int k = 0; k < 16; k++) s += coef(j - k) * longint'(xi[k]);
            tbl[5].b[j] = 16'(s);
            tbl[5].x[j] = 32'(longint'(xi[j]) * 65536);
        end
        tbl[6]          = tbl[5];
        tbl[5].x[7]     = tbl[5].x[7] + 32'd3;
        tbl[5].exp_pass = 1'b1;
        tbl[6].x[7]     = tbl[6].x[7] + 32'd4;
        tbl[6].mode     = 2'd1;

        repeat (3) @(negedge clk);
        chk("reset_r_valid", longint'(r_valid), 0);
        chk("reset_r_out", longint'(r_out), 0);
        chk("reset_r_idx", longint'(r_idx), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_pass", longint'(pass), 0);
        @(posedge clk);
        #2 reset = 1'b1;

        for (int t = 0; t < 7; t++) begin
            run_frame(tbl[t], $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_exp_pass", t), longint'(done_pass), longint'(tbl[t].exp_pass));
            if (t == 1 && rq_val.size() == 16) begin
                chk("unit_r0", rq_val[0], 64'sh14_0000);
                chk("unit_r1", rq_val[1], -64'shD_0000);
                chk("unit_r2", rq_val[2], 64'sh6_0000);
                chk("unit_r3", rq_val[3], -64'sh1_0000);
                for (int i = 4; i < 16; i++) chk($sformatf("unit_r%0d", i), rq_val[i], 0);
            end
        end

        // Golden solution of M x = b by Gauss-Seidel in reals, quantised to Q16.16
        v = '0;
        for (int j = 0; j < 16; j++) begin
            v.b[j] = 16'(int'($urandom_range(0, 200)) - 100);
            xr[j]  = 0.0;
        end
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < 16; i++) begin
                real acc;
                acc = real'($signed(v.b[i]));
                for (int k = 0; k < 16; k++)
                    if (k != i) acc -= real'(coef(i - k)) * xr[k];
                xr[i] = acc / 20.0;
            end
        end
        for (int i = 0; i < 16; i++) v.x[i] = 32'(longint'(xr[i] * 65536.0));
        v.mode = 2'd1;
        run_frame(v, "golden");
        chk("golden_pass_req", longint'(done_pass), 1);

        for (int f = 0; f < 5; f++) begin
            v = '0;
            for (int j = 0; j < 16; j++) begin
                v.b[j] = 16'(int'($urandom_range(0, 2000)) - 1000);
                v.x[j] = 32'($signed(20'($urandom)));
            end
            v.mode = 2'($urandom_range(0, 3));
            run_frame(v, $sformatf("rand%0d", f));
        end

        // Reset while row 7 is on the outputs
        rq_val.delete();
        d0 = done_cnt;
        send_frame(tbl[2]);
        n = 0;
        while (!(r_valid && r_idx == 4'd7) && n < 40) begin
            @(negedge clk);
            #1;
            in_en   = 1'b0;
            x_valid = 1'b0;
            n++;
        end
        chk("rst_reached_row7", longint'(r_valid && r_idx == 4'd7), 1);
        reset = 1'b0;
        #1;
        chk("rst_r_valid", longint'(r_valid), 0);
        chk("rst_r_out", longint'(r_out), 0);
        chk("rst_r_idx", longint'(r_idx), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pass", longint'(pass), 0);
        repeat (25) @(negedge clk);
        chk("rst_no_done", longint'(done_cnt - d0), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        run_frame(tbl[6], "after_rst");
        run_frame(tbl[3], "after_rst2");

        chk("pass_only_with_done", longint'(stray), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
